score_keeper: RTL and testbench

- Upstream feeder of the on-screen text overlay. Turns game-event pulses into the 16-bit binary score and high score that the overlay converts to BCD and draws.
- Applies point values and the ghost-combo doubling rule.
- Saturates the score at the 4-digit display limit.
- Clears the score at the start of each game and pulses an extra-life award.

---
 rtl/score_keeper.sv | 146 ++++++++++++++
 tb/tb_score_keeper.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Turns game-event pulses into a saturating binary score/high score; optional extra-life award (SCORE_EXTRA_LIFE_EN).
// Latency: score 1 cycle after event, high_score 2 cycles; no backpressure, events outside PLAY are dropped.
package score_keeper_pkg;
    typedef enum logic [2:0] {
        GAME_MODE_LOADING    = 3'd0,
        GAME_MODE_READY      = 3'd1,
        GAME_MODE_PLAYING    = 3'd2,
        GAME_MODE_DYING      = 3'd3,
        GAME_MODE_LEVEL_DONE = 3'd4,
        GAME_MODE_FAIL       = 3'd5
    } game_mode_t;
endpackage

module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int MAX_SCORE      = 9999,
    parameter int PELLET_PTS     = 10,
    parameter int POWER_PTS      = 50,
    parameter int FRUIT_PTS      = 100,
    parameter int GHOST_BASE_PTS = 200
`ifdef SCORE_EXTRA_LIFE_EN
    ,
    parameter int EXTRA_LIFE_AT  = 5000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  game_mode_t  MODE,
    input  logic        pellet_eaten,
    input  logic        power_eaten,
    input  logic        ghost_eaten,
    input  logic        fruit_eaten,
    input  logic        fright_end,
    output logic [15:0] score,
    output logic [15:0] high_score,
    output logic [1:0]  combo_idx,
    output logic        extra_life
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t     state, state_nxt;
    game_mode_t prev_mode;
    logic       new_game;
    logic       events_ok;
    logic [1:0] combo_eff;
    logic [1:0] combo_nxt;
    logic [16:0] delta;
    logic [16:0] sum;
    logic [15:0] score_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_PLAY;
        case (MODE)
            GAME_MODE_LOADING, GAME_MODE_READY: state_nxt = ST_IDLE;
            GAME_MODE_FAIL:                     state_nxt = ST_OVER;
            default:                            state_nxt = ST_PLAY;
        endcase
    end

    assign new_game  = (MODE == GAME_MODE_READY) && (prev_mode != GAME_MODE_READY);
    assign events_ok = (state == ST_PLAY);

    // A power pellet restarts the fright period, so a coincident ghost is the first one.
    assign combo_eff = power_eaten ? 2'd0 : combo_idx;

    always_comb begin
        delta = 17'd0;
        if (pellet_eaten) delta = delta + 17'(PELLET_PTS);
        if (power_eaten)  delta = delta + 17'(POWER_PTS);
        if (fruit_eaten)  delta = delta + 17'(FRUIT_PTS);
        if (ghost_eaten)  delta = delta + (17'(GHOST_BASE_PTS) << combo_eff);
    end

    assign sum       = {1'b0, score} + delta;
    assign score_nxt = (sum > 17'(MAX_SCORE)) ? 16'(MAX_SCORE) : sum[15:0];

    always_comb begin
        combo_nxt = combo_idx;
        if (power_eaten) begin
            combo_nxt = ghost_eaten ? 2'd1 : 2'd0;
        end else if (fright_end) begin
            combo_nxt = 2'd0;
        end else if (ghost_eaten && combo_idx != 2'd3) begin
            combo_nxt = combo_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_mode  <= GAME_MODE_LOADING;
            score      <= 16'd0;
            high_score <= 16'd0;
            combo_idx  <= 2'd0;
        end else begin
            prev_mode <= MODE;
            // Tracks the registered score, so it lags score by one cycle.
            if (score > high_score) high_score <= score;
            if (new_game) begin
                score     <= 16'd0;
                combo_idx <= 2'd0;
            end else if (events_ok) begin
                score     <= score_nxt;
                combo_idx <= combo_nxt;
            end
        end
    end

`ifdef SCORE_EXTRA_LIFE_EN
    logic life_armed;
    logic life_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            life_armed <= 1'b1;
            life_pulse <= 1'b0;
        end else if (new_game) begin
            life_armed <= 1'b1;
            life_pulse <= 1'b0;
        end else if (events_ok && life_armed && (score_nxt >= 16'(EXTRA_LIFE_AT))) begin
            life_armed <= 1'b0;
            life_pulse <= 1'b1;
        end else begin
            life_pulse <= 1'b0;
        end
    end

    assign extra_life = life_pulse;
`else
    assign extra_life = 1'b0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: scoring model compared every cycle plus hand-computed checkpoints.
module tb_score_keeper;
    import score_keeper_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    game_mode_t  mode = GAME_MODE_LOADING;
    logic        pellet_eaten = 1'b0;
    logic        power_eaten = 1'b0;
    logic        ghost_eaten = 1'b0;
    logic        fruit_eaten = 1'b0;
    logic        fright_end = 1'b0;
    logic [15:0] score;
    logic [15:0] high_score;
    logic [1:0]  combo_idx;
    logic        extra_life;

    int checks = 0;
    int failures = 0;

`ifdef SCORE_EXTRA_LIFE_EN
    localparam int LIFE_ON = 1;
`else
    localparam int LIFE_ON = 0;
`endif

    score_keeper dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .MODE         (mode),
        .pellet_eaten (pellet_eaten),
        .power_eaten  (power_eaten),
        .ghost_eaten  (ghost_eaten),
        .fruit_eaten  (fruit_eaten),
        .fright_end   (fright_end),
        .score        (score),
        .high_score   (high_score),
        .combo_idx    (combo_idx),
        .extra_life   (extra_life)
    );

    always #5 clk = ~clk;

    // Reference model: ghost count per fright period, plain integer score arithmetic.
    int  m_score = 0;
    int  m_high = 0;
    int  m_ghosts = 0;
    int  m_life = 0;
    bit  m_armed = 1'b1;
    bit  m_play = 1'b0;
    game_mode_t m_prev = GAME_MODE_LOADING;

    function automatic int ghost_value(input int ghosts_so_far);
        case (ghosts_so_far)
            0:       return 200;
            1:       return 400;
            2:       return 800;
            default: return 1600;
        endcase
    endfunction

    function automatic bit is_play(input game_mode_t m);
        return !(m == GAME_MODE_LOADING || m == GAME_MODE_READY || m == GAME_MODE_FAIL);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_score = 0; m_high = 0; m_ghosts = 0; m_life = 0;
            m_armed = 1'b1; m_play = 1'b0; m_prev = GAME_MODE_LOADING;
        end else begin
            int total;
            if (m_score > m_high) m_high = m_score;
            m_life = 0;
            if (mode == GAME_MODE_READY && m_prev != GAME_MODE_READY) begin
                m_score = 0; m_ghosts = 0; m_armed = 1'b1;
            end else if (m_play) begin
                total = m_score + 10 * pellet_eaten + 50 * power_eaten + 100 * fruit_eaten;
                if (power_eaten) m_ghosts = 0;
                if (ghost_eaten) total += ghost_value(m_ghosts);
                m_score = (total > 9999) ? 9999 : total;
                if (power_eaten)     m_ghosts = ghost_eaten ? 1 : 0;
                else if (fright_end) m_ghosts = 0;
                else if (ghost_eaten) m_ghosts++;
                if (LIFE_ON != 0 && m_armed && m_score >= 5000) begin
                    m_life = 1; m_armed = 1'b0;
                end
            end
            m_play = is_play(mode);
            m_prev = mode;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_score", int'(score), m_score);
        check("model_high", int'(high_score), m_high);
        check("model_combo", int'(combo_idx), (m_ghosts > 3) ? 3 : m_ghosts);
        check("model_life", int'(extra_life), m_life);
    end

    task automatic step(input logic p, input logic pw, input logic g, input logic f, input logic fe);
        pellet_eaten = p; power_eaten = pw; ghost_eaten = g; fruit_eaten = f; fright_end = fe;
        @(negedge clk);
        pellet_eaten = 0; power_eaten = 0; ghost_eaten = 0; fruit_eaten = 0; fright_end = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic start_game();
        mode = GAME_MODE_FAIL;    idle(2);
        mode = GAME_MODE_READY;   idle(2);
        mode = GAME_MODE_PLAYING; idle(2);
    endtask

    int exp_a [5] = '{280, 680, 1480, 3080, 4680};
    int exp_c [5] = '{1, 2, 3, 3, 3};

    initial begin
        idle(3);
        check("reset_score", int'(score), 0);
        check("reset_high", int'(high_score), 0);
        check("reset_combo", int'(combo_idx), 0);
        check("reset_life", int'(extra_life), 0);
        rst_n = 1'b1;
        mode = GAME_MODE_READY;   idle(2);
        mode = GAME_MODE_PLAYING; idle(2);

        // Pellets, then a full fright period of ghosts
        step(1, 0, 0, 0, 0); check("pellet1", int'(score), 10);
        step(1, 0, 0, 0, 0); check("pellet2", int'(score), 20);
        step(1, 0, 0, 0, 0); check("pellet3", int'(score), 30);
        check("high_lag", int'(high_score), 20);
        step(0, 1, 0, 0, 0); check("high_30", int'(high_score), 30);
        check("power_score", int'(score), 80);
        check("power_combo", int'(combo_idx), 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0, 0);
            check("ghost_score", int'(score), exp_a[i]);
            check("ghost_combo", int'(combo_idx), exp_c[i]);
        end
        step(0, 0, 0, 0, 1); check("fright_end_combo", int'(combo_idx), 0);

        // Combo interactions
        start_game();
        check("newgame_score", int'(score), 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0); check("combo2", int'(combo_idx), 2);
        step(0, 1, 1, 0, 0); check("power_ghost_score", int'(score), 900);
        check("power_ghost_combo", int'(combo_idx), 1);
        step(0, 0, 0, 0, 1); check("fright_end_c0", int'(combo_idx), 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 1); check("ghost_fright_score", int'(score), 1550);
        check("ghost_fright_combo", int'(combo_idx), 0);

        // Extra life and saturation
        start_game();
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
        check("pre_life_score", int'(score), 4990);
        check("pre_life_pulse", int'(extra_life), 0);
        step(1, 0, 0, 0, 0); check("life_score", int'(score), 5000);
        check("life_pulse", int'(extra_life), LIFE_ON);
        step(1, 0, 0, 0, 0); check("life_pulse_end", int'(extra_life), 0);
        for (int i = 0; i < 49; i++) step(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0);
        check("pre_sat_score", int'(score), 9990);
        step(0, 0, 0, 1, 0); check("sat_score", int'(score), 9999);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        check("sat_hold", int'(score), 9999);

        // Asynchronous reset mid-game
        #2 rst_n = 1'b0;
        #1;
        check("async_score", int'(score), 0);
        check("async_high", int'(high_score), 0);
        check("async_combo", int'(combo_idx), 0);
        check("async_life", int'(extra_life), 0);
        mode = GAME_MODE_LOADING;
        @(negedge clk);
        rst_n = 1'b1;

        // Ignored events, game over and new game
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0); check("loading_ignored", int'(score), 0);
        mode = GAME_MODE_READY;   idle(2);
        mode = GAME_MODE_PLAYING; idle(2);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        check("score_1230", int'(score), 1230);
        mode = GAME_MODE_FAIL; idle(2);
        step(1, 0, 0, 0, 0); check("over_ignored", int'(score), 1230);
        mode = GAME_MODE_READY;
        step(1, 0, 0, 0, 0); check("ready_clear", int'(score), 0);
        check("ready_high", int'(high_score), 1230);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
